// File: rtl/fp_seq_subtractor.sv
// Sequential magnitude subtractor |A| - |B| for IEEE-754 single precision, truncating, no special values.
// Define FP_SEQ_SUB_SERIAL_NORM_EN to normalise one bit per cycle instead of with a full shifter.
module fp_seq_subtractor (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] Out,
  output logic        out_valid,
  input  logic        out_ready
);

  typedef enum logic [2:0] {IDLE, ALIGN, SUB, NORM, DONE} state_t;

  state_t      state_q, state_d;
  logic [30:0] a_q, a_d, b_q, b_d;
  logic        sign_q, sign_d;
  logic [7:0]  ex_q, ex_d;
  logic [23:0] mx_q, mx_d, my_q, my_d;
  logic [23:0] d_q, d_d;
  logic [31:0] out_q, out_d;

  // Sign bits of the operands play no part in a magnitude subtraction.
  logic unused_sign;
  assign unused_sign = A[31] ^ B[31];

  logic [7:0]  ea, eb, ex_w, ey_w, sh_w;
  logic [23:0] ma, mb, mx_w, my_w, my_sh;
  logic        b_gt;

  assign ea    = a_q[30:23];
  assign eb    = b_q[30:23];
  assign ma    = (ea != 8'd0) ? {1'b1, a_q[22:0]} : 24'd0;
  assign mb    = (eb != 8'd0) ? {1'b1, b_q[22:0]} : 24'd0;
  assign b_gt  = {eb, mb} > {ea, ma};
  assign ex_w  = b_gt ? eb : ea;
  assign ey_w  = b_gt ? ea : eb;
  assign mx_w  = b_gt ? mb : ma;
  assign my_w  = b_gt ? ma : mb;
  assign sh_w  = ex_w - ey_w;
  assign my_sh = (sh_w >= 8'd24) ? 24'd0 : (my_w >> sh_w);

`ifndef FP_SEQ_SUB_SERIAL_NORM_EN
  function automatic logic [4:0] lzc(input logic [23:0] v);
    lzc = 5'd24;
    for (int i = 0; i < 24; i++) begin
      if (v[i]) lzc = 5'(23 - i);
    end
  endfunction

  logic [4:0]  lz_w;
  logic [22:0] frac_w;
  logic        flush_w;

  assign lz_w    = lzc(d_q);
  assign frac_w  = 23'(d_q << lz_w);
  assign flush_w = (d_q == 24'd0) || (ex_q <= {3'b000, lz_w});
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sign_d  = sign_q;
    ex_d    = ex_q;
    mx_d    = mx_q;
    my_d    = my_q;
    d_d     = d_q;
    out_d   = out_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = A[30:0];
          b_d     = B[30:0];
          state_d = ALIGN;
        end
      end
      ALIGN: begin
        sign_d  = b_gt;
        ex_d    = ex_w;
        mx_d    = mx_w;
        my_d    = my_sh;
        state_d = SUB;
      end
      SUB: begin
        d_d     = mx_q - my_q;
        state_d = NORM;
      end
      NORM: begin
`ifdef FP_SEQ_SUB_SERIAL_NORM_EN
        if (d_q == 24'd0) begin
          out_d   = 32'd0;
          state_d = DONE;
        end else if (d_q[23]) begin
          out_d   = {sign_q, ex_q, d_q[22:0]};
          state_d = DONE;
        end else if (ex_q <= 8'd1) begin
          // Another shift would take the exponent to zero: flush to +0.
          out_d   = 32'd0;
          state_d = DONE;
        end else begin
          d_d  = {d_q[22:0], 1'b0};
          ex_d = ex_q - 8'd1;
        end
`else
        if (flush_w) out_d = 32'd0;
        else         out_d = {sign_q, ex_q - {3'b000, lz_w}, frac_w};
        state_d = DONE;
`endif
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sign_q  <= 1'b0;
      ex_q    <= '0;
      mx_q    <= '0;
      my_q    <= '0;
      d_q     <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sign_q  <= sign_d;
      ex_q    <= ex_d;
      mx_q    <= mx_d;
      my_q    <= my_d;
      d_q     <= d_d;
      out_q   <= out_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign Out       = out_q;

endmodule
